// File: rtl/lin_part_seq.sv
// Bit-serial linear (XOR) half of the linearised adder: latches one carry per clock
// from the AND terms returned by nonlin_part, then presents sum/cout with valid/ready.
module lin_part_seq #(
    parameter int NBIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NBIT-1:0]     a_in,
    input  logic [NBIT-1:0]     b_in,
    output logic [NBIT-2:0]     a_nl,
    output logic [NBIT-2:0]     b_nl,
    output logic [NBIT-4:0]     r,
    input  logic [3*NBIT-6:0]   nl,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NBIT-1:0]     sum,
    output logic                cout,
    output logic                busy
);

    localparam int NLW = 3 * NBIT - 5;
    localparam int KW  = $clog2(NBIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RIPPLE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [NBIT-1:0]     r_a_q;
    logic [NBIT-1:0]     r_b_q;
    logic [NBIT-4:0]     r_semi;
    logic                r_c_last;
    logic [KW-1:0]       r_k;
    logic [NBIT-1:0]     r_sum;
    logic                r_cout;
    logic                r_out_valid;
    logic [NBIT-1:0]     w_carry;

    // Majority of three bits expressed as the XOR of the pairwise AND terms.
    function automatic logic triple(input logic [NLW-1:0] v, input int j);
        return v[3*j+1] ^ v[3*j+2] ^ v[3*j+3];
    endfunction

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (in_valid) w_next = S_RIPPLE;
            S_RIPPLE: if (r_k == KW'(NBIT - 3)) w_next = S_DONE;
            S_DONE:   if (r_out_valid && out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_carry = {r_c_last, r_semi, nl[0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_q       <= '0;
            r_b_q       <= '0;
            r_semi      <= '0;
            r_c_last    <= 1'b0;
            r_k         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_q    <= a_in;
                        r_b_q    <= b_in;
                        r_semi   <= '0;
                        r_c_last <= 1'b0;
                        r_k      <= '0;
                    end
                end
                S_RIPPLE: begin
                    // triple(k) only reads r bits below k, which are already settled.
                    if (r_k == KW'(NBIT - 3)) begin
                        r_c_last <= triple(nl, NBIT - 3);
                    end else begin
                        for (int j = 0; j < NBIT - 3; j++) begin
                            if (r_k == KW'(j)) r_semi[j] <= triple(nl, j);
                        end
                        r_k <= r_k + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!r_out_valid) begin
                        r_sum       <= r_a_q ^ r_b_q ^ w_carry;
                        r_cout      <= majority(r_a_q[NBIT-1], r_b_q[NBIT-1], r_c_last);
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign busy      = (r_state != S_IDLE);
    assign a_nl      = r_a_q[NBIT-2:0];
    assign b_nl      = r_b_q[NBIT-2:0];
    assign r         = r_semi;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule
